// File: rtl/memory_accesser.sv
// Memory-access stage: runs loads/stores on a req/ack port and emits one writeback record per
// instruction. Define MEMORY_ACCESSER_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module memory_accesser #(
    parameter int unsigned Timeout = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] exec_result_i,
    input  logic [31:0] rs2_val_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        mem_err_o,
    output logic        misalign_o
);

    localparam int unsigned CntW = (Timeout > 2) ? $clog2(Timeout) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Timeout - 1);

    typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ready_q;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [3:0]      mem_wstrb_q, mem_wstrb_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [2:0]      ld_f3_q, ld_f3_d;
    logic [1:0]      ld_off_q, ld_off_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic            mem_err_q, mem_err_d;
    logic            misalign_q, misalign_d;

    logic [1:0]  off;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        trap;
    logic        accept;

    assign off    = exec_result_i[1:0];
    assign accept = in_valid_i & in_ready_o;

`ifdef MEMORY_ACCESSER_MISALIGN_TRAP_EN
    assign trap = (is_load_i | is_store_i) &
                  (((funct3_i[1:0] == 2'b01) & off[0]) | (funct3_i[1] & (off != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        lane_strb  = 4'b1111;
        lane_wdata = rs2_val_i;
        case (funct3_i[1:0])
            2'b00: begin
                lane_strb  = 4'b0001 << off;
                lane_wdata = {4{rs2_val_i[7:0]}};
            end
            2'b01: begin
                lane_strb  = 4'b0011 << {off[1], 1'b0};
                lane_wdata = {2{rs2_val_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load formatting uses the size/offset latched at accept time.
    always_comb begin
        ld_byte = mem_rdata_i[{ld_off_q, 3'b000} +: 8];
        ld_half = ld_off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (ld_f3_q[1:0])
            2'b00:   ld_data = {{24{~ld_f3_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~ld_f3_q[2] & ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        ld_f3_d     = ld_f3_q;
        ld_off_d    = ld_off_q;
        wb_we_d     = wb_we_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        mem_err_d   = 1'b0;
        misalign_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    wb_rd_d = rd_i;
                    cnt_d   = '0;
                    if (trap) begin
                        state_d    = StResp;
                        wb_we_d    = 1'b0;
                        wb_data_d  = exec_result_i;
                        misalign_d = 1'b1;
                    end else if (is_load_i || is_store_i) begin
                        state_d     = StMem;
                        mem_we_d    = is_store_i;
                        mem_addr_d  = {exec_result_i[31:2], 2'b00};
                        mem_wstrb_d = lane_strb;
                        mem_wdata_d = is_store_i ? lane_wdata : 32'h0;
                        ld_f3_d     = funct3_i;
                        ld_off_d    = off;
                    end else begin
                        state_d   = StResp;
                        wb_we_d   = (rd_i != 5'd0);
                        wb_data_d = exec_result_i;
                    end
                end
            end
            StMem: begin
                // An ACK arriving in the expiry cycle still completes the access.
                if (mem_ack_i) begin
                    state_d   = StResp;
                    wb_we_d   = ~mem_we_q & (wb_rd_q != 5'd0);
                    wb_data_d = mem_we_q ? 32'h0 : ld_data;
                end else if (Timeout != 0 && cnt_q == CntMax) begin
                    state_d   = StResp;
                    mem_err_d = 1'b1;
                    wb_we_d   = 1'b0;
                    wb_data_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wstrb_q <= 4'h0;
            mem_wdata_q <= 32'h0;
            ld_f3_q     <= 3'h0;
            ld_off_q    <= 2'h0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'h0;
            wb_data_q   <= 32'h0;
            mem_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= 1'b1;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            ld_f3_q     <= ld_f3_d;
            ld_off_q    <= ld_off_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            mem_err_q   <= mem_err_d;
            misalign_q  <= misalign_d;
        end
    end

    // ready_q keeps IN_READY low through reset and until the first edge after release.
    assign in_ready_o  = ready_q & (state_q == StIdle);
    assign mem_req_o   = (state_q == StMem);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wstrb_o = mem_wstrb_q;
    assign mem_wdata_o = mem_wdata_q;
    assign wb_valid_o  = (state_q == StResp);
    assign wb_we_o     = wb_we_q & wb_valid_o;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign mem_err_o   = mem_err_q;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_memory_accesser.sv
// Bench for memory_accesser: directed plan items plus random ops against an arithmetic model.
module tb_memory_accesser;

    localparam int TO = 4;

    logic        clk, rst_n;
    logic        in_valid, in_ready, is_load, is_store;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] exec_result, rs2_val;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        wb_valid, wb_we, mem_err, misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    memory_accesser #(.Timeout(TO)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .is_load_i    (is_load),
        .is_store_i   (is_store),
        .funct3_i     (funct3),
        .rd_i         (rd),
        .exec_result_i(exec_result),
        .rs2_val_i    (rs2_val),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wstrb_o  (mem_wstrb),
        .mem_wdata_o  (mem_wdata),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata),
        .wb_valid_o   (wb_valid),
        .wb_we_o      (wb_we),
        .wb_rd_o      (wb_rd),
        .wb_data_o    (wb_data),
        .mem_err_o    (mem_err),
        .misalign_o   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Byte offset actually used for the access once the size masks the low bits.
    function automatic int lane_off(input logic [2:0] f3, input logic [1:0] off);
        int n = nbytes(f3);
        return (n == 4) ? 0 : (int'(off) / n) * n;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
        int n = nbytes(f3);
        logic [31:0] mask, v;
        if (n == 4) return word;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = (word >> (8 * lane_off(f3, off))) & mask;
        if (!f3[2] && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] off);
        int n = nbytes(f3);
        logic [31:0] s;
        s = ((32'd1 << n) - 32'd1) << lane_off(f3, off);
        return s[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] v);
        logic [31:0] b, h;
        b = {24'h0, v[7:0]};
        h = {16'h0, v[15:0]};
        case (nbytes(f3))
            1:       return b * 32'h0101_0101;
            2:       return h * 32'h0001_0001;
            default: return v;
        endcase
    endfunction

    function automatic logic m_trap(input logic mem, input logic [2:0] f3, input logic [1:0] off);
`ifdef MEMORY_ACCESSER_MISALIGN_TRAP_EN
        int n = nbytes(f3);
        return mem && (int'(off) % n != 0);
`else
        return 1'b0 & mem & f3[0] & off[0];
`endif
    endfunction

    // One instruction end to end; ack_at is the MEM cycle (1-based) carrying MEM_ACK, 0 = never.
    task automatic do_op(input logic ld, input logic st, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] res, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int ack_at);
        logic is_mem, trap, tmo;
        logic [31:0] exp_data;
        logic exp_we;
        is_mem = ld | st;
        trap   = m_trap(is_mem, f3, res[1:0]);
        tmo    = is_mem && !trap && (ack_at < 1 || ack_at > TO);
        if (trap)          exp_data = res;
        else if (tmo)      exp_data = 32'h0;
        else if (st)       exp_data = 32'h0;
        else if (ld)       exp_data = m_load(f3, res[1:0], rdata);
        else               exp_data = res;
        exp_we = !(trap || tmo || st) && (r != 5'd0);

        chk("in_ready_idle", in_ready, 1);
        in_valid = 1; is_load = ld; is_store = st; funct3 = f3; rd = r;
        exec_result = res; rs2_val = rs2;
        mem_ack = 1; mem_rdata = ~rdata;
        @(posedge clk); #1;
        in_valid = 0; mem_ack = 0;
        is_load = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
        rd = 5'($urandom); exec_result = $urandom; rs2_val = $urandom;

        if (is_mem && !trap) begin
            chk("in_ready_busy", in_ready, 0);
            chk("mem_addr", mem_addr, res & 32'hFFFF_FFFC);
            chk("mem_we", mem_we, st);
            if (st) begin
                chk("mem_wstrb", mem_wstrb, m_strb(f3, res[1:0]));
                chk("mem_wdata", mem_wdata, m_wdata(f3, rs2));
            end
            for (int k = 1; k <= TO; k++) begin
                chk("mem_req_held", mem_req, 1);
                if (k == ack_at) begin
                    mem_ack = 1; mem_rdata = rdata;
                end
                @(posedge clk); #1;
                mem_ack = 0; mem_rdata = $urandom;
                if (k == ack_at) break;
            end
        end else begin
            chk("no_mem_req", mem_req, 0);
        end

        chk("wb_valid", wb_valid, 1);
        chk("mem_req_done", mem_req, 0);
        chk("wb_we", wb_we, exp_we);
        chk("wb_rd", wb_rd, r);
        if (!(st && !trap && !tmo)) chk("wb_data", wb_data, exp_data);
        chk("mem_err", mem_err, tmo);
        chk("misalign", misalign, trap);
        @(posedge clk); #1;
        chk("wb_valid_pulse", wb_valid, 0);
        chk("mem_err_pulse", mem_err, 0);
    endtask

    initial begin
        rst_n = 0; in_valid = 0; is_load = 0; is_store = 0; funct3 = 0; rd = 0;
        exec_result = 0; rs2_val = 0; mem_ack = 0; mem_rdata = 0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_mem_err", mem_err, 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1; #1;
        chk("in_ready_before_edge", in_ready, 0);
        @(posedge clk); #1;
        chk("in_ready_after_edge", in_ready, 1);

        do_op(0, 0, 3'b000, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 0);           // ALU pass-through
        do_op(1, 0, 3'b000, 5'd7, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3);   // LB
        do_op(1, 0, 3'b100, 5'd7, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3);   // LBU
        do_op(0, 1, 3'b001, 5'd3, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 1);   // SH
        do_op(1, 0, 3'b010, 5'd9, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 0);   // timeout
        do_op(1, 0, 3'b010, 5'd9, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, TO);  // ACK at expiry
        do_op(1, 0, 3'b010, 5'd0, 32'h0000_0040, 32'h0, 32'h1234_5678, 1);   // RD=0 load
        do_op(1, 0, 3'b010, 5'd4, 32'h0000_0041, 32'h0, 32'h1234_5678, 1);   // LW misaligned
        do_op(1, 0, 3'b001, 5'd4, 32'h0000_0043, 32'h0, 32'h8001_7FFE, 2);   // LH odd offset
        do_op(1, 1, 3'b000, 5'd6, 32'h0000_0501, 32'h0000_00A5, 32'h0, 2);   // load+store -> store
        do_op(0, 1, 3'b000, 5'd6, 32'h0000_0600, 32'h1, 32'h0, 0);           // store timeout

        // Reset while a load is outstanding.
        chk("in_ready_pre_rst", in_ready, 1);
        in_valid = 1; is_load = 1; is_store = 0; funct3 = 3'b010; rd = 5'd8;
        exec_result = 32'h0000_0700;
        @(posedge clk); #1;
        in_valid = 0;
        chk("mid_req_on", mem_req, 1);
        #2; rst_n = 0; #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_wb", wb_valid, 0);
        mem_ack = 1;
        @(posedge clk); @(negedge clk);
        rst_n = 1; #1;
        chk("mid_rel_ready", in_ready, 0);
        @(posedge clk); #1;
        mem_ack = 0;
        chk("mid_ready_after", in_ready, 1);
        chk("mid_no_wb", wb_valid, 0);
        chk("mid_no_req", mem_req, 0);
        @(posedge clk); #1;
        chk("mid_no_wb_later", wb_valid, 0);

        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            do_op(kind == 1 || kind == 3, kind >= 2, 3'($urandom), 5'($urandom), $urandom,
                  $urandom, $urandom, $urandom_range(0, TO + 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_accesser.md
Name: memory_accesser

Overview:
- Memory-access stage that sits directly downstream of the execute stage.
- Consumes the execute result (EXEC_RESULT) plus the decoded load/store info and RS2_VAL.
- Runs load/store transactions on a req/ack data-memory port, sign- or zero-extends load data, and presents one writeback record per accepted instruction.
- Non-memory instructions pass through with one-cycle latency.

Parameters:
- TIMEOUT, 16: max cycles MEM_REQ is held without MEM_ACK before the access is aborted; 0 = no timeout.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  reset: asynchronous, active-low.
- IN_VALID  in  1  execute stage presents an instruction.
- IN_READY  out  1  stage can accept; accept = IN_VALID & IN_READY.
- IS_LOAD  in  1  instruction is a load.
- IS_STORE  in  1  instruction is a store.
- FUNCT3  in  3  access size/sign.
- RD  in  5  destination register.
- EXEC_RESULT  in  32  ALU result, or effective address for loads/stores.
- RS2_VAL  in  32  store data.
- MEM_REQ  out  1  memory request, held until MEM_ACK or abort.
- MEM_WE  out  1  1 = store.
- MEM_ADDR  out  32  word-aligned address, {addr[31:2],2'b00}.
- MEM_WSTRB  out  4  byte enables.
- MEM_WDATA  out  32  lane-aligned store data.
- MEM_ACK  in  1  memory completes the request this cycle.
- MEM_RDATA  in  32  read word, valid with MEM_ACK.
- WB_VALID  out  1  one-cycle pulse; writeback record valid.
- WB_WE  out  1  write RD.
- WB_RD  out  5  destination.
- WB_DATA  out  32  result.
- MEM_ERR  out  1  pulse with WB_VALID when the access timed out.
- MISALIGN  out  1  pulse with WB_VALID on a trapped misaligned access; tied 0 unless the macro below is defined.

Behaviour:
- Reset (async, RSTN=0):
  - All outputs 0, including IN_READY; IN_READY goes to 1 on the first clock edge after reset release.
  - FSM returns to IDLE; timeout counter cleared.
  - Reset mid-transaction drops MEM_REQ immediately and abandons the access; no WB_VALID is produced for it.
- FSM states:
  - IDLE: IN_READY=1.
  - MEM: MEM_REQ=1, IN_READY=0.
  - RESP: WB_VALID=1 for one cycle, IN_READY=0.
- Transitions:
  - IDLE, accept, !IS_LOAD & !IS_STORE -> RESP. WB_DATA=EXEC_RESULT, WB_WE=(RD!=0). Latency: 1 cycle.
  - IDLE, accept, load or store -> MEM. MEM_* outputs are registered at the accept edge and stay stable while in MEM.
  - MEM & MEM_ACK -> RESP.
    - Loads: capture formatted MEM_RDATA; WB_WE=(RD!=0).
    - Stores: WB_WE=0.
    - Minimum latency accept->WB_VALID is 2 cycles.
  - MEM & counter==TIMEOUT-1 & !MEM_ACK (TIMEOUT>0) -> RESP with MEM_ERR=1, WB_WE=0, WB_DATA=0. MEM_REQ drops the same edge.
  - MEM_ACK on the same cycle as timeout expiry: the ACK wins.
  - RESP -> IDLE unconditionally.
- IS_LOAD & IS_STORE both 1: treated as a store.
- Lane handling, off=EXEC_RESULT[1:0]:
  - Byte (FUNCT3[1:0]=00): WSTRB=4'b0001<<off; WDATA=byte replicated x4; load selects byte off.
  - Half (01): WSTRB=4'b0011<<{off[1],1'b0}; WDATA=half replicated x2; load selects half off[1].
  - Word (10, and 11): WSTRB=4'b1111; WDATA=RS2_VAL.
- Load extension: FUNCT3[2]=0 sign-extends, 1 zero-extends. 011/110/111 are treated as LW.
- MEM_ACK outside MEM state is ignored.
- MEM_RDATA is sampled only when MEM_ACK=1.

Optional Feature:
- Macro: MEMORY_ACCESSER_MISALIGN_TRAP_EN.
- Defined:
  - Trapped cases: half access with off[0]=1, or word access with off!=0.
  - A trapped access issues no MEM_REQ and goes IDLE -> RESP directly.
  - Response: WB_VALID with MISALIGN=1, WB_WE=0, WB_DATA=EXEC_RESULT (the faulting address).
- Not defined: MISALIGN is tied 0 and the low offset bits are masked as in the lane rules above, so a half uses off[1] and a word ignores off.

Test Plan:
- ALU pass-through: accept EXEC_RESULT=0x0000_1234, RD=5, no load/store -> next cycle WB_VALID=1, WB_WE=1, WB_RD=5, WB_DATA=0x0000_1234; no MEM_REQ.
- LB sign-extend: addr 0x103, MEM_RDATA=0x80FF_0000, ACK after 3 cycles -> MEM_ADDR=0x100, MEM_REQ held 3 cycles, WB_DATA=0xFFFF_FF80. Same stimulus with LBU -> 0x0000_0080.
- SH: addr 0x202, RS2_VAL=0xDEAD_BEEF, ACK immediate -> MEM_WE=1, WSTRB=4'b1100, WDATA=0xBEEF_BEEF; WB_VALID with WB_WE=0 two cycles after accept.
- Timeout: TIMEOUT=4, load, MEM_ACK never asserted -> MEM_REQ high exactly 4 cycles, then WB_VALID and MEM_ERR pulse together, WB_WE=0; ACK on the 4th cycle instead completes the load normally.
- Reset mid-access: RSTN low while in MEM -> MEM_REQ=0 immediately, no WB_VALID; IN_READY=1 on the first clock edge after RSTN release.
- RD=0 load: LW at 0x40, MEM_RDATA=0x1234_5678 -> WB_VALID=1, WB_WE=0. With the macro defined, LW at 0x41 -> no MEM_REQ, MISALIGN=1, WB_DATA=0x41.
